// File: rtl/viterbi_codec_if.sv
// viterbi_codec_if: bundles the encoder and decoder strobe/data signals of viterbi_codec.
// Ports: enable_i/d_in in, valid_o/d_out_enc out (encoder); dec_enable/dec_in in, d_out/dec_valid out (decoder).
// master = datapath driving the codec, slave = the codec itself. No backpressure signals exist.
interface viterbi_codec_if;
  logic       enable_i;
  logic       d_in;
  logic       valid_o;
  logic [1:0] d_out_enc;
  logic       dec_enable;
  logic [1:0] dec_in;
  logic       d_out;
  logic       dec_valid;

  modport master (
    output enable_i, d_in, dec_enable, dec_in,
    input  valid_o, d_out_enc, d_out, dec_valid
  );

  modport slave (
    input  enable_i, d_in, dec_enable, dec_in,
    output valid_o, d_out_enc, d_out, dec_valid
  );
endinterface

// File: rtl/viterbi_codec.sv
// viterbi_codec: rate-1/2 K=3 convolutional encoder (g=111,101) plus hard-decision register-exchange Viterbi decoder.
// Latency: encoder 1 cycle; decoder emits bit n-TB_DEPTH+1 the cycle after accepting symbol n (n >= TB_DEPTH).
// Backpressure: none; both paths accept one item per clock whenever strobed.
// Ports: clk, rst (sync, active-high); io_cdc (viterbi_codec_if.slave) carries all strobes and data.
// Build option: VITERBI_CODEC_LOOPBACK_EN feeds the decoder from the encoder output through one extra register
// and ignores dec_enable/dec_in; ports are the same in both builds.
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  viterbi_codec_if.slave io_cdc
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  // ---------------- encoder ----------------
  logic [1:0] r_enc_s;       // {s1, s0}, s1 = most recent past bit
  logic       r_valid_o;
  logic [1:0] r_d_out_enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_s     <= 2'b00;
      r_valid_o   <= 1'b0;
      r_d_out_enc <= 2'b00;
    end else begin
      r_valid_o <= io_cdc.enable_i;
      if (io_cdc.enable_i) begin
        r_d_out_enc <= {io_cdc.d_in ^ r_enc_s[1] ^ r_enc_s[0], io_cdc.d_in ^ r_enc_s[0]};
        r_enc_s     <= {io_cdc.d_in, r_enc_s[1]};
      end
    end
  end

  assign io_cdc.valid_o   = r_valid_o;
  assign io_cdc.d_out_enc = r_d_out_enc;

  // ---------------- decoder input select ----------------
  logic       w_dec_en;
  logic [1:0] w_dec_sym;

`ifdef VITERBI_CODEC_LOOPBACK_EN
  logic       r_lb_vld;
  logic [1:0] r_lb_sym;
  logic       w_unused_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lb_vld <= 1'b0;
      r_lb_sym <= 2'b00;
    end else begin
      r_lb_vld <= r_valid_o;
      r_lb_sym <= r_d_out_enc;
    end
  end

  assign w_dec_en     = r_lb_vld;
  assign w_dec_sym    = r_lb_sym;
  assign w_unused_dec = ^{io_cdc.dec_enable, io_cdc.dec_in};
`else
  assign w_dec_en  = io_cdc.dec_enable;
  assign w_dec_sym = io_cdc.dec_in;
`endif

  // ---------------- decoder ----------------
  logic [3:0][PM_W-1:0]     r_pm;
  logic [3:0][TB_DEPTH-1:0] r_surv;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_d_out;
  logic                     r_dec_valid;

  logic [3:0][PM_W-1:0]     w_pm_new;
  logic [3:0][TB_DEPTH-1:0] w_surv_new;
  logic [PM_W-1:0]          w_min;
  logic [1:0]               w_best;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Metrics stick at PM_MAX instead of wrapping, so a saturated path can never look cheap.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // ACS for next state {d, s1}: predecessors {s1,0} and {s1,1}.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS   = 2'(g);
    localparam logic       D    = NS[1];
    localparam logic       S1   = NS[0];
    localparam int         P0   = 2 * g % 4;      // {S1,0}
    localparam int         P1   = 2 * g % 4 + 1;  // {S1,1}
    localparam logic [1:0] EXP0 = {D ^ S1, D};
    localparam logic [1:0] EXP1 = {~(D ^ S1), ~D};

    logic [PM_W-1:0]     w_c0;
    logic [PM_W-1:0]     w_c1;
    logic                w_sel1;
    logic [TB_DEPTH-1:0] w_surv_win;

    assign w_c0          = sat_add(r_pm[P0], hamming(w_dec_sym, EXP0));
    assign w_c1          = sat_add(r_pm[P1], hamming(w_dec_sym, EXP1));
    assign w_sel1        = (w_c1 < w_c0);  // tie keeps the s0=0 predecessor
    assign w_pm_new[g]   = w_sel1 ? w_c1 : w_c0;
    assign w_surv_win    = w_sel1 ? r_surv[P1] : r_surv[P0];
    assign w_surv_new[g] = {w_surv_win[TB_DEPTH-2:0], D};
  end

  // Strict '<' keeps the lowest index on ties.
  always_comb begin
    w_min  = w_pm_new[0];
    w_best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_pm_new[i] < w_min) begin
        w_min  = w_pm_new[i];
        w_best = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm        <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      r_surv      <= '0;
      r_cnt       <= '0;
      r_d_out     <= 1'b0;
      r_dec_valid <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      if (w_dec_en) begin
        for (int i = 0; i < 4; i++) begin
          r_pm[i]   <= w_pm_new[i] - w_min;
          r_surv[i] <= w_surv_new[i];
        end
        if (r_cnt != CNT_TOP) r_cnt <= r_cnt + 1'b1;
        // Decision uses the survivors just produced, so the output lines up with this symbol.
        r_d_out     <= w_surv_new[w_best][TB_DEPTH-1];
        r_dec_valid <= (r_cnt >= CNT_LAST);
      end
    end
  end

  assign io_cdc.d_out     = r_d_out;
  assign io_cdc.dec_valid = r_dec_valid;

endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: encoder output is fed back to the decoder through the bench, with optional
// symbol corruption, stalls and mid-stream reset; a negedge monitor checks against queued expectations.
// Expected symbols come from a bit-history model of the generators; expected decoded bits are the input bits.
module tb_viterbi_codec;
  localparam int TB   = 16;
  localparam int PM_W = 8;
  localparam int NBIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_codec_if bus ();

  viterbi_codec #(.TB_DEPTH(TB), .PM_W(PM_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_cdc(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] enc_q[$];
  bit         dec_q[$];
  bit         hist[$];
  bit         stream[NBIT];
  int         dec_cnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Code symbol from the last two information bits since reset (zeros before that).
  function automatic logic [1:0] model_sym(input bit d);
    int n = hist.size();
    bit b1, b2;
    b1 = (n > 0) ? hist[n-1] : 1'b0;
    b2 = (n > 1) ? hist[n-2] : 1'b0;
    hist.push_back(d);
    return {d ^ b1 ^ b2, d ^ b2};
  endfunction

  // One clock: forward last encoder output to the decoder (maybe corrupted), present a new encoder bit.
  task automatic step(input bit en, input bit d, input bit flip, input int fixed);
    logic [1:0] sym;
    @(posedge clk); #1;
    sym = bus.d_out_enc;
    if (bus.valid_o) begin
      if (flip && (dec_cnt % 8 == 7)) sym = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      dec_cnt++;
    end
    bus.dec_enable = bus.valid_o;
    bus.dec_in     = sym;
    bus.enable_i   = en;
    bus.d_in       = en ? d : 1'($urandom_range(0, 1));
    if (en) begin
      if (fixed >= 0) begin
        enc_q.push_back(2'(fixed));
        hist.push_back(d);
      end else begin
        enc_q.push_back(model_sym(d));
      end
      dec_q.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.enable_i   = 1'b0;
    bus.dec_enable = 1'b0;
    hist.delete();
    dec_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic run_stream(input int n, input bit flip, input int gap_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle(5);
      if (i == rst_at) do_reset();
      step(1'b1, stream[i], flip, -1);
    end
  endtask

  task automatic end_phase(input string nm);
    idle(4);
    check({nm, "_enc_q_left"}, enc_q.size(), 0);
    check({nm, "_dec_q_left"}, dec_q.size(), TB - 1);
  endtask

  // Monitor: compares every cycle, away from the rising edge.
  bit         prev_en  = 1'b0;
  bit         prev_den = 1'b0;
  int         acc      = 0;
  logic [1:0] last_sym = 2'b00;
  bit         last_dout = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      enc_q.delete();
      dec_q.delete();
      prev_en   = 1'b0;
      prev_den  = 1'b0;
      acc       = 0;
      last_sym  = 2'b00;
      last_dout = 1'b0;
    end else begin
      check("valid_o", int'(bus.valid_o), int'(prev_en));
      if (bus.valid_o) begin
        if (enc_q.size() == 0) check("enc_extra", enc_q.size(), 1);
        else begin
          last_sym = enc_q.pop_front();
          check("d_out_enc", int'(bus.d_out_enc), int'(last_sym));
        end
      end else begin
        check("d_out_enc_hold", int'(bus.d_out_enc), int'(last_sym));
      end
      check("dec_valid", int'(bus.dec_valid), int'(prev_den && (acc >= TB)));
      if (bus.dec_valid) begin
        if (dec_q.size() == 0) check("dec_extra", dec_q.size(), 1);
        else begin
          last_dout = dec_q.pop_front();
          check("d_out", int'(bus.d_out), int'(last_dout));
        end
      end else begin
        check("d_out_hold", int'(bus.d_out), int'(last_dout));
      end
      prev_en  = bus.enable_i;
      prev_den = bus.dec_enable;
      if (bus.dec_enable) acc++;
    end
  end

  initial begin
    bus.enable_i   = 1'b0;
    bus.d_in       = 1'b0;
    bus.dec_enable = 1'b0;
    bus.dec_in     = 2'b00;

    // Directed encoder sequence with literal expectations.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1);
    idle(4);
    check("directed_enc_q_left", enc_q.size(), 0);

    for (int i = 0; i < NBIT; i++) stream[i] = 1'($urandom_range(0, 1));

    do_reset(); run_stream(NBIT, 1'b0, -1, -1);  end_phase("clean");
    do_reset(); run_stream(NBIT, 1'b1, -1, -1);  end_phase("flip8");
    do_reset(); run_stream(NBIT, 1'b0, 100, -1); end_phase("gap");
    do_reset(); run_stream(150, 1'b0, -1, 50);   end_phase("midreset");

    for (int i = 0; i < NBIT; i++) stream[i] = 1'b1;
    do_reset(); run_stream(40, 1'b0, -1, -1);    end_phase("ones");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
